jt7759_feeder: RTL and testbench
================================

// Module: jt7759_feeder
// PURPOSE
//  Host-side streamer driving the uPD7759 passive (slave, mdn=0) data port.
//  Fetches a byte block from sample ROM into a small prefetch FIFO and writes one
//  byte per drqn request through cs/wrn/dout. Sits between the game ROM
//  controller and the jt7759 core when the core runs in slave mode.
// PARAMETERS
//  AW        17  ROM address and length width (bits)
//  FIFO_AW    2  log2 of prefetch FIFO depth (default depth 4)
//  WR_PULSE   2  wrn low time, counted in cen ticks (>=1)
// PORTS
//  clk         in   1     system clock
//  rstn        in   1     asynchronous active-low reset
//  cen         in   1     clock enable for write-strobe timing
//  start       in   1     1-cycle pulse: begin block transfer (ignored while busy)
//  start_addr  in   AW    first ROM byte address of block
//  length      in   AW    number of bytes in block
//  abort       in   1     1-cycle pulse: cancel transfer
//  busy        out  1     transfer in progress
//  done        out  1     1-cycle pulse: last byte written or length==0
//  rom_cs      out  1     ROM request; held with stable rom_addr until rom_ok
//  rom_addr    out  AW    ROM byte address
//  rom_data    in   8     ROM read data, valid when rom_ok
//  rom_ok      in   1     ROM data valid for current rom_addr
//  drqn        in   1     data request from jt7759, active low
//  cs          out  1     chip select to jt7759 (high while writing)
//  wrn         out  1     write strobe to jt7759, active low
//  dout        out  8     byte presented to jt7759 din
// BEHAVIOUR
//  Async reset (rstn=0): busy=0, done=0, rom_cs=0, rom_addr=0, cs=0, wrn=1, dout=0,
//   FIFO empty, pending request cleared, state IDLE.
//  States: IDLE -> RUN on start (abort=0). length==0: done pulses next cycle, stays IDLE.
//   start latches rom_addr<=start_addr, fetch_left<=length, write_left<=length.
//  Fetcher (RUN): rom_cs=1 whenever fetch_left>0 and FIFO not full.
//   Cycle with rom_cs&rom_ok: push rom_data, rom_addr+1 (wraps mod 2^AW),
//   fetch_left-1; rom_cs drops same cycle if FIFO becomes full or fetch_left hits 0.
//   rom_addr never changes while rom_cs=1 and rom_ok=0.
//  Request detect: drqn falling edge (drqn_l=1, drqn=0) sets req_pend; only one
//   pending request held (further edges while pending are merged).
//  Writer: WR_IDLE -> WR_STB when req_pend and FIFO non-empty: dout<=FIFO head,
//   cs=1, wrn=0, req_pend cleared. wrn held low WR_PULSE cen ticks, then
//   WR_END one clk: wrn=1, cs=0, pop FIFO, write_left-1. dout stable through WR_STB.
//   Request with empty FIFO waits; write starts cycle after first push.
//  Fetch and write in the same cycle: push and pop both act, occupancy unchanged.
//  Completion: write_left reaches 0 in WR_END -> done pulse next cycle, busy=0,
//   IDLE. drqn edges in IDLE ignored (req_pend not set).
//  abort (any state, wins over simultaneous start): next cycle IDLE, busy=0,
//   rom_cs=0, cs=0, wrn=1, FIFO flushed, req_pend=0, no done pulse;
//   an in-flight strobe is cut short. rom_addr keeps its value.
//  Reset mid-transfer: identical to power-on reset values above.
//  busy=1 from cycle after start through the done cycle (exclusive).
// TESTING
//  start_addr=0x100,len=3, ROM returns addr LSB, rom_ok 1-cycle latency, drqn pulses
//   low every 40 clk -> jt7759 sees 0x00,0x01,0x02 on cs&~wrn; done once; busy=0.
//  len=0 start -> done pulses next cycle, rom_cs never asserted, busy stays 0.
//  rom_ok delayed 20 clk, drqn falls at t=1 -> write deferred until push; wrn low
//   exactly WR_PULSE cen ticks; rom_addr stable while waiting.
//  start_addr=0x1FFFE,len=4 -> rom_addr sequence 1FFFE,1FFFF,00000,00001.
//  len=10, no drqn -> exactly 4 ROM reads (FIFO full), rom_cs=0 afterwards.
//  abort during wrn=0 with start same cycle -> next cycle IDLE, cs=0,wrn=1, no done;
//   new start then replays block from its start_addr correctly.

Source files
------------

// File: rtl/jt7759_feeder.sv
`default_nettype none
//============================================================================
// Module   : jt7759_feeder
// Desc     : Host-side streamer for the uPD7759 slave-mode data port. Fetches
//            a byte block from sample ROM into a small prefetch FIFO and
//            writes one byte per drqn request through cs/wrn/dout.
// Revision : 1.0 - initial release
//============================================================================
module jt7759_feeder #(
  parameter int AW       = 17,
  parameter int FIFO_AW  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] length,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  input  logic          drqn,
  output logic          cs,
  output logic          wrn,
  output logic [7:0]    dout
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam int                 SW        = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [SW-1:0]      STB_LAST  = SW'(WR_PULSE - 1);
  localparam logic [FIFO_AW:0]   FIFO_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } main_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_STB  = 2'd1,
    WR_END  = 2'd2
  } wr_t;

  main_t              st_q, st_d;
  wr_t                ws_q, ws_d;
  logic [AW-1:0]      rom_addr_q, rom_addr_d;
  logic [AW-1:0]      fetch_left_q, fetch_left_d;
  logic [AW-1:0]      write_left_q, write_left_d;
  logic               drqn_l_q, drqn_l_d;
  logic               req_pend_q, req_pend_d;
  logic               done_q, done_d;
  logic [7:0]         dout_q, dout_d;
  logic [SW-1:0]      stb_cnt_q, stb_cnt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];

  logic run;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic drq_fall;

  assign run        = (st_q == ST_RUN);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  // The ROM request only depends on registered state, so rom_addr is
  // guaranteed stable for as long as rom_cs waits on rom_ok.
  assign rom_cs     = run && (fetch_left_q != '0) && !fifo_full;
  assign push       = rom_cs && rom_ok;
  assign pop        = (ws_q == WR_END);
  assign drq_fall   = drqn_l_q && !drqn;

  assign busy     = run;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign cs       = (ws_q == WR_STB);
  assign wrn      = (ws_q != WR_STB);
  assign dout     = dout_q;

  // FIFO storage: written on every accepted ROM byte, contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rom_data;
    end
  end

  // Next-state for transfer control, fetcher, request detect, writer and FIFO
  always_comb begin
    st_d         = st_q;
    ws_d         = ws_q;
    rom_addr_d   = rom_addr_q;
    fetch_left_d = fetch_left_q;
    write_left_d = write_left_q;
    drqn_l_d     = drqn;
    req_pend_d   = req_pend_q;
    done_d       = 1'b0;
    dout_d       = dout_q;
    stb_cnt_d    = stb_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    case (st_q)
      ST_IDLE: begin
        // Requests arriving outside a transfer are not remembered
        req_pend_d = 1'b0;
        ws_d       = WR_IDLE;
        if (start) begin
          rom_addr_d   = start_addr;
          fetch_left_d = length;
          write_left_d = length;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            st_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (push) begin
          rom_addr_d   = rom_addr_q + AW'(1);
          fetch_left_d = fetch_left_q - AW'(1);
          wr_ptr_d     = wr_ptr_q + FIFO_AW'(1);
        end

        // One pending request at most; extra edges merge into it
        req_pend_d = req_pend_q | drq_fall;

        case (ws_q)
          WR_IDLE: begin
            // A byte being pushed this cycle is forwarded straight to dout so
            // a waiting request is served the cycle after the push.
            if (req_pend_q && (!fifo_empty || push)) begin
              ws_d       = WR_STB;
              dout_d     = fifo_empty ? rom_data : mem_q[rd_ptr_q];
              stb_cnt_d  = '0;
              req_pend_d = drq_fall;
            end
          end
          WR_STB: begin
            if (cen) begin
              if (stb_cnt_q == STB_LAST) begin
                ws_d = WR_END;
              end else begin
                stb_cnt_d = stb_cnt_q + SW'(1);
              end
            end
          end
          WR_END: begin
            ws_d         = WR_IDLE;
            rd_ptr_d     = rd_ptr_q + FIFO_AW'(1);
            write_left_d = write_left_q - AW'(1);
            if (write_left_q == AW'(1)) begin
              st_d       = ST_IDLE;
              done_d     = 1'b1;
              req_pend_d = 1'b0;
            end
          end
          default: ws_d = WR_IDLE;
        endcase
      end

      default: st_d = ST_IDLE;
    endcase

    // Simultaneous push and pop leave the occupancy unchanged
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Abort beats everything, including a start in the same cycle; the ROM
    // address is left where the fetcher stopped.
    if (abort) begin
      st_d         = ST_IDLE;
      ws_d         = WR_IDLE;
      rom_addr_d   = rom_addr_q;
      fetch_left_d = '0;
      write_left_d = '0;
      req_pend_d   = 1'b0;
      done_d       = 1'b0;
      dout_d       = dout_q;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q         <= ST_IDLE;
      ws_q         <= WR_IDLE;
      rom_addr_q   <= '0;
      fetch_left_q <= '0;
      write_left_q <= '0;
      drqn_l_q     <= 1'b1;
      req_pend_q   <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      stb_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      st_q         <= st_d;
      ws_q         <= ws_d;
      rom_addr_q   <= rom_addr_d;
      fetch_left_q <= fetch_left_d;
      write_left_q <= write_left_d;
      drqn_l_q     <= drqn_l_d;
      req_pend_q   <= req_pend_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      stb_cnt_q    <= stb_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jt7759_feeder.sv
`default_nettype none
//============================================================================
// Module   : tb_jt7759_feeder
// Desc     : Directed self-checking bench for jt7759_feeder with a ROM
//            responder, drqn generator and write-strobe monitor.
// Revision : 1.0 - initial release
//============================================================================
module tb_jt7759_feeder;

  localparam int AW  = 17;
  localparam int WRP = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cen = 1'b0;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic          drqn;
  logic          cs;
  logic          wrn;
  logic [7:0]    dout;

  int errors = 0;
  int checks = 0;

  // environment state
  int            cyc = 0;
  int            rom_lat = 1;
  int            rom_wait = 0;
  logic [AW-1:0] rom_addr_prev = '0;
  int            addr_err = 0;
  logic          drq_auto = 1'b0;
  int            drq_cnt = 0;
  int            done_cnt = 0;
  logic          rom_cs_seen = 1'b0;
  logic          in_stb = 1'b0;
  logic [7:0]    stb_dout = '0;
  int            stb_ticks = 0;
  int            dout_err = 0;
  int            rok_cyc = 0;
  int            stb_cyc = 0;
  logic [AW-1:0] rom_log [$];
  logic [7:0]    wr_log [$];
  int            pulse_log [$];

  jt7759_feeder #(.AW(AW), .FIFO_AW(2), .WR_PULSE(WRP)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cen       (cen),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .drqn      (drqn),
    .cs        (cs),
    .wrn       (wrn),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  // Environment: drives cen/drqn/ROM on the falling edge, then monitors
  always @(negedge clk) begin
    cyc = cyc + 1;
    cen = ~cen;
    if (drq_auto) begin
      drqn    = (drq_cnt < 2) ? 1'b0 : 1'b1;
      drq_cnt = (drq_cnt == 39) ? 0 : drq_cnt + 1;
    end
    if (rom_ok) begin
      rom_ok   = 1'b0;
      rom_wait = 0;
    end else if (rom_cs && rstn) begin
      if (rom_wait != 0 && rom_addr !== rom_addr_prev) addr_err = addr_err + 1;
      rom_addr_prev = rom_addr;
      rom_wait      = rom_wait + 1;
      if (rom_wait > rom_lat) begin
        rom_ok   = 1'b1;
        rom_data = rom_addr[7:0];
        rok_cyc  = cyc;
        rom_log.push_back(rom_addr);
      end
    end else begin
      rom_wait = 0;
    end
    if (rstn) begin
      if (done) done_cnt = done_cnt + 1;
      if (rom_cs) rom_cs_seen = 1'b1;
      if (cs && !wrn) begin
        if (!in_stb) begin
          wr_log.push_back(dout);
          stb_dout  = dout;
          stb_ticks = 0;
          stb_cyc   = cyc;
          in_stb    = 1'b1;
        end else if (dout !== stb_dout) begin
          dout_err = dout_err + 1;
        end
        if (cen) stb_ticks = stb_ticks + 1;
      end else if (in_stb) begin
        in_stb = 1'b0;
        pulse_log.push_back(stb_ticks);
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] l);
    @(negedge clk);
    start = 1'b1; start_addr = a; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    rom_log.delete(); wr_log.delete(); pulse_log.delete();
    done_cnt = 0; rom_cs_seen = 1'b0; addr_err = 0; dout_err = 0;
  endtask

  task automatic set_drq_auto(input logic en);
    @(negedge clk);
    drq_cnt  = 0;
    drq_auto = en;
    @(negedge clk);
    if (!en) drqn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); end
    checks++; if (rom_addr !== 17'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", cs); end
    checks++; if (wrn !== 1'b1) begin errors++; $display("FAIL reset_wrn: got %b expected 1", wrn); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    int n;
    exp_b[0] = 8'h00; exp_b[1] = 8'h01; exp_b[2] = 8'h02;
    rom_lat = 1;
    clear_logs();
    set_drq_auto(1'b1);
    do_start(17'h00100, 17'd3);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (done_cnt == 0) begin errors++; $display("FAIL basic_timeout: got no done expected done within 3000 cycles"); end
    repeat (3) @(negedge clk);
    checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL basic_count: got %0d writes expected 3", wr_log.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_log.size() || wr_log[i] !== exp_b[i]) begin
        errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, (i < wr_log.size()) ? wr_log[i] : 8'hxx, exp_b[i]);
      end
    end
    for (int i = 0; i < pulse_log.size(); i++) begin
      checks++; if (pulse_log[i] != WRP) begin errors++; $display("FAIL basic_pulse%0d: got %0d ticks expected %0d", i, pulse_log[i], WRP); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_once: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    checks++; if (dout_err != 0) begin errors++; $display("FAIL basic_dout_stable: got %0d changes expected 0", dout_err); end
  endtask

  task automatic test_zero_len();
    set_drq_auto(1'b0);
    clear_logs();
    do_start(17'h00040, 17'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
    repeat (10) @(negedge clk);
    checks++; if (rom_cs_seen !== 1'b0) begin errors++; $display("FAIL zero_rom_cs: got %b expected 0", rom_cs_seen); end
  endtask

  task automatic test_deferred();
    int n;
    rom_lat = 20;
    clear_logs();
    do_start(17'h00055, 17'd1);
    drqn = 1'b0;
    @(negedge clk);
    drqn = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 500) begin @(negedge clk); n++; end
    checks++; if (done_cnt == 0) begin errors++; $display("FAIL defer_timeout: got no done expected done within 500 cycles"); end
    repeat (3) @(negedge clk);
    checks++; if (wr_log.size() != 1 || wr_log[0] !== 8'h55) begin errors++; $display("FAIL defer_byte: got %0d writes first %h expected 1 write of 55", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 8'hxx); end
    checks++; if (pulse_log.size() != 1 || pulse_log[0] != WRP) begin errors++; $display("FAIL defer_pulse: got %0d ticks expected %0d", (pulse_log.size() > 0) ? pulse_log[0] : -1, WRP); end
    checks++; if (stb_cyc - rok_cyc != 1) begin errors++; $display("FAIL defer_start_latency: got %0d cycles after push expected 1", stb_cyc - rok_cyc); end
    checks++; if (addr_err != 0) begin errors++; $display("FAIL defer_addr_stable: got %0d changes expected 0", addr_err); end
    checks++; if (rom_log.size() != 1) begin errors++; $display("FAIL defer_reads: got %0d expected 1", rom_log.size()); end
    rom_lat = 1;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    logic [7:0]    exp_b [4];
    int n;
    exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000; exp_a[3] = 17'h00001;
    exp_b[0] = 8'hFE; exp_b[1] = 8'hFF; exp_b[2] = 8'h00; exp_b[3] = 8'h01;
    clear_logs();
    set_drq_auto(1'b1);
    do_start(17'h1FFFE, 17'd4);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (done_cnt == 0) begin errors++; $display("FAIL wrap_timeout: got no done expected done within 3000 cycles"); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rom_log.size() || rom_log[i] !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, (i < rom_log.size()) ? rom_log[i] : 17'hx, exp_a[i]);
      end
      checks++;
      if (i >= wr_log.size() || wr_log[i] !== exp_b[i]) begin
        errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, (i < wr_log.size()) ? wr_log[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    set_drq_auto(1'b0);
    clear_logs();
    do_start(17'h00400, 17'd10);
    repeat (100) @(negedge clk);
    checks++; if (rom_log.size() != 4) begin errors++; $display("FAIL full_reads: got %0d expected 4", rom_log.size()); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL full_rom_cs: got %b expected 0", rom_cs); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_abort_busy: got %b expected 0", busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort_restart();
    int n;
    clear_logs();
    set_drq_auto(1'b1);
    do_start(17'h00200, 17'd2);
    n = 0;
    while (!(cs && !wrn) && n < 2000) begin @(negedge clk); n++; end
    checks++; if (!(cs && !wrn)) begin errors++; $display("FAIL abort_no_strobe: got no strobe expected strobe within 2000 cycles"); end
    abort = 1'b1; start = 1'b1; start_addr = 17'h00300; length = 17'd5;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL abort_cs: got %b expected 0", cs); end
    checks++; if (wrn !== 1'b1) begin errors++; $display("FAIL abort_wrn: got %b expected 1", wrn); end
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL abort_rom_cs: got %b expected 0", rom_cs); end
    repeat (60) @(negedge clk);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", busy); end
    clear_logs();
    do_start(17'h00200, 17'd2);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (done_cnt == 0) begin errors++; $display("FAIL replay_timeout: got no done expected done within 3000 cycles"); end
    repeat (3) @(negedge clk);
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL replay_count: got %0d expected 2", wr_log.size()); end
    checks++; if (wr_log.size() < 1 || wr_log[0] !== 8'h00) begin errors++; $display("FAIL replay_byte0: got %h expected 00", (wr_log.size() > 0) ? wr_log[0] : 8'hxx); end
    checks++; if (wr_log.size() < 2 || wr_log[1] !== 8'h01) begin errors++; $display("FAIL replay_byte1: got %h expected 01", (wr_log.size() > 1) ? wr_log[1] : 8'hxx); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL replay_done_once: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0;
    rom_data = 8'h00; rom_ok = 1'b0; drqn = 1'b1;
    test_reset();
    test_basic();
    test_zero_len();
    test_deferred();
    test_wrap();
    test_fifo_full();
    test_abort_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
